// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Load hits return combinationally; load misses and every store stall the core until mem_ack.
module data_cache #(
    parameter int INDEX_BITS = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [31:0]           cpu_wdata,
    input  logic [3:0]            cpu_be,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_be,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ack,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count,
    output logic [1:0]            dbg_state
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2
    } state_t;

    state_t                state;
    logic [LINES-1:0]      valid;
    logic [TAG_BITS-1:0]   tag_store [LINES];
    logic [31:0]           data      [LINES];
    logic                  done_flag;

    logic [INDEX_BITS-1:0] index;
    logic [INDEX_BITS-1:0] m_index;
    logic [TAG_BITS-1:0]   tag;
    logic [TAG_BITS-1:0]   m_tag;
    logic                  is_idle;
    logic                  hit;
    logic                  load_hit;
    logic                  load_miss;
    logic                  start_wr;
    logic                  wr_hit;
    logic [31:0]           byte_mask;
    logic                  unused_offset;

    assign index   = cpu_addr[INDEX_BITS+1:2];
    assign tag     = cpu_addr[ADDR_WIDTH-1:INDEX_BITS+2];
    assign m_index = mem_addr[INDEX_BITS+1:2];
    assign m_tag   = mem_addr[ADDR_WIDTH-1:INDEX_BITS+2];
    assign unused_offset = ^cpu_addr[1:0];

    assign is_idle   = (state == IDLE);
    assign hit       = cpu_req & valid[index] & (tag_store[index] == tag);
    assign load_hit  = is_idle & hit & ~cpu_we;
    assign load_miss = is_idle & cpu_req & ~cpu_we & ~hit;
    // A store still presented in the cycle after its own mem_ack must retire, not restart.
    assign start_wr  = is_idle & cpu_req & cpu_we & ~done_flag;
    assign wr_hit    = valid[m_index] & (tag_store[m_index] == m_tag);
    assign byte_mask = {{8{mem_be[3]}}, {8{mem_be[2]}}, {8{mem_be[1]}}, {8{mem_be[0]}}};

    assign cpu_stall = ~is_idle | load_miss | start_wr;
    assign cpu_rdata = load_hit ? data[index] : 32'd0;
    assign dbg_state = state;

    // Memory handshake: mem_req and the mem_* payload are registered on entry to
    // RD_MISS/WR_THRU and held stable until the single-cycle mem_ack pulse; mem_ack
    // seen in any other state is ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            valid      <= '0;
            done_flag  <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'd0;
            mem_be     <= 4'd0;
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else begin
            done_flag <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_miss) begin
                        state      <= RD_MISS;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
                        miss_count <= miss_count + 32'd1;
                    end else if (load_hit) begin
                        if (!done_flag) begin
                            hit_count <= hit_count + 32'd1;
                        end
                    end else if (start_wr) begin
                        state     <= WR_THRU;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_wdata <= cpu_wdata;
                        mem_be    <= cpu_be;
                    end
                end
                RD_MISS: begin
                    if (mem_ack) begin
                        valid[m_index] <= 1'b1;
                        mem_req        <= 1'b0;
                        done_flag      <= 1'b1;
                        state          <= IDLE;
                    end
                end
                WR_THRU: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        done_flag <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reset forces IDLE asynchronously, so the arrays never see a write while rst is low.
    always_ff @(posedge clk) begin
        if (state == RD_MISS && mem_ack) begin
            data[m_index]      <= mem_rdata;
            tag_store[m_index] <= m_tag;
        end else if (state == WR_THRU && mem_ack && wr_hit) begin
            data[m_index] <= (data[m_index] & ~byte_mask) | (mem_wdata & byte_mask);
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: array-based cache model, one negedge compare process,
// and literal expectations taken from the hand-worked scenarios.
module tb_data_cache;

    localparam int LINES = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] hit_count;
    logic [31:0] miss_count;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    data_cache #(.INDEX_BITS(8), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_count(hit_count), .miss_count(miss_count),
        .dbg_state(dbg_state)
    );

    // Cache contents as the rules say they must be.
    bit          m_valid [LINES];
    logic [21:0] m_tag   [LINES];
    logic [31:0] m_data  [LINES];

    logic [31:0] exp_q[$];
    logic [31:0] exp_hits;
    logic [31:0] exp_misses;
    logic        exp_stall;
    logic        exp_mem_req;
    logic        exp_mem_we;
    logic [31:0] exp_mem_addr;
    logic [31:0] exp_mem_wdata;
    logic [3:0]  exp_mem_be;
    logic        rdata_chk;
    logic        chk_en;
    logic        rst_chk;
    logic        lit_on;
    int          lit_kind;
    logic [31:0] lit_exp;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_rdata = 32'd0;
    logic [31:0] exp_word;
    int          stall_run = 0;
    int          last_run = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rst_chk) begin
            chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
            chk("rst_hit_count", hit_count, 32'd0);
            chk("rst_miss_count", miss_count, 32'd0);
            chk("rst_state", {30'd0, dbg_state}, 32'd0);
            if (!cpu_req) begin
                chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
                chk("rst_rdata", cpu_rdata, 32'd0);
            end
        end else if (rst && chk_en) begin
            if (cpu_stall) begin
                stall_run++;
            end else begin
                if (stall_run > 0) last_run = stall_run;
                stall_run = 0;
            end
            chk("stall", {31'd0, cpu_stall}, {31'd0, exp_stall});
            chk("mem_req", {31'd0, mem_req}, {31'd0, exp_mem_req});
            chk("hit_count", hit_count, exp_hits);
            chk("miss_count", miss_count, exp_misses);
            if (exp_mem_req) begin
                chk("mem_we", {31'd0, mem_we}, {31'd0, exp_mem_we});
                chk("mem_addr", mem_addr, exp_mem_addr);
                if (exp_mem_we) begin
                    chk("mem_wdata", mem_wdata, exp_mem_wdata);
                    chk("mem_be", {28'd0, mem_be}, {28'd0, exp_mem_be});
                end
            end
            if (rdata_chk && exp_q.size() != 0) begin
                exp_word = exp_q.pop_front();
                chk("rdata", cpu_rdata, exp_word);
                last_rdata = cpu_rdata;
            end
            if (lit_on) begin
                case (lit_kind)
                    0: chk("lit_rdata", last_rdata, lit_exp);
                    1: chk("lit_hit_count", hit_count, lit_exp);
                    2: chk("lit_miss_count", miss_count, lit_exp);
                    default: chk("lit_stall_cycles", last_run, lit_exp);
                endcase
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input int kind, input logic [31:0] value);
        lit_kind = kind;
        lit_exp  = value;
        lit_on   = 1'b1;
        step();
        lit_on = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        exp_hits    = 32'd0;
        exp_misses  = 32'd0;
        exp_stall   = 1'b0;
        exp_mem_req = 1'b0;
    endtask

    // One core access, run to retirement; n = cycles from mem_req rising to mem_ack.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int n, input logic [31:0] rd);
        int          idx;
        logic [21:0] tg;
        bit          present;
        logic [31:0] mask;
        idx     = int'((addr >> 2) % LINES);
        tg      = addr[31:10];
        present = m_valid[idx] && (m_tag[idx] == tg);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_be = be;
        if (!we && present) begin
            exp_stall = 1'b0;
            exp_q.push_back(m_data[idx]);
            rdata_chk = 1'b1;
            step();
            rdata_chk = 1'b0;
            exp_hits  = exp_hits + 32'd1;
        end else begin
            exp_stall = 1'b1;
            step();
            if (!we) exp_misses = exp_misses + 32'd1;
            exp_mem_req  = 1'b1;
            exp_mem_we   = we;
            exp_mem_addr = addr & 32'hFFFF_FFFC;
            if (we) begin
                exp_mem_wdata = wdata;
                exp_mem_be    = be;
            end
            for (int k = 1; k <= n; k++) begin
                mem_ack   = (k == n);
                mem_rdata = (k == n) ? rd : 32'h0BAD_F00D;
                step();
            end
            mem_ack     = 1'b0;
            exp_mem_req = 1'b0;
            if (!we) begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tg;
                m_data[idx]  = rd;
            end else if (present) begin
                mask = 32'd0;
                for (int b = 0; b < 4; b++) if (be[b]) mask = mask | (32'hFF << (8 * b));
                m_data[idx] = (m_data[idx] & ~mask) | (wdata & mask);
            end
            exp_stall = 1'b0;
            if (!we) begin
                exp_q.push_back(rd);
                rdata_chk = 1'b1;
            end
            step();
            rdata_chk = 1'b0;
        end
        cpu_req   = 1'b0;
        exp_stall = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0; cpu_be = 4'd0;
        mem_ack = 1'b0; mem_rdata = 32'd0;
        chk_en = 1'b0; rst_chk = 1'b1; lit_on = 1'b0; lit_kind = 0; lit_exp = 32'd0;
        rdata_chk = 1'b0; exp_mem_we = 1'b0; exp_mem_addr = 32'd0;
        exp_mem_wdata = 32'd0; exp_mem_be = 4'd0;
        model_reset();
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1; rst_chk = 1'b0; chk_en = 1'b1;

        // Cold miss with a three-cycle memory, then the same word hits.
        access(1'b0, 32'h100, 32'd0, 4'h0, 3, 32'hDEAD_BEEF);
        lit(3, 32'd4);
        lit(0, 32'hDEAD_BEEF);
        lit(2, 32'd1);
        lit(1, 32'd0);
        access(1'b0, 32'h100, 32'd0, 4'h0, 1, 32'd0);
        lit(1, 32'd1);

        // Byte-lane store into a cached line.
        access(1'b1, 32'h100, 32'h0000_00AA, 4'b0001, 2, 32'd0);
        access(1'b0, 32'h100, 32'd0, 4'h0, 1, 32'd0);
        lit(0, 32'hDEAD_BEAA);

        // Store to an uncached word does not allocate; ack arrives with mem_req.
        access(1'b1, 32'h2000, 32'h1234_5678, 4'b1111, 1, 32'd0);
        access(1'b0, 32'h2000, 32'd0, 4'h0, 1, 32'hCAFE_F00D);
        lit(2, 32'd2);

        // Stray ack while idle.
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;

        // Upper-half store merges into the refilled line.
        access(1'b1, 32'h2000, 32'hABCD_0000, 4'b1100, 4, 32'd0);
        access(1'b0, 32'h2000, 32'd0, 4'h0, 1, 32'd0);
        lit(0, 32'hABCD_F00D);

        // Reset two cycles into a read miss, then a late ack.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h900;
        exp_stall = 1'b1;
        step();
        exp_misses   = exp_misses + 32'd1;
        exp_mem_req  = 1'b1; exp_mem_we = 1'b0; exp_mem_addr = 32'h900;
        step();
        step();
        chk_en = 1'b0; rst_chk = 1'b1;
        #2 rst = 1'b0;
        model_reset();
        step();
        cpu_req = 1'b0;
        rst = 1'b1; rst_chk = 1'b0; chk_en = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        step();
        mem_ack = 1'b0;
        lit(2, 32'd0);

        // Aliasing lines at index 0x40 replace each other.
        access(1'b0, 32'h100, 32'd0, 4'h0, 2, 32'h1111_1111);
        access(1'b0, 32'h500, 32'd0, 4'h0, 2, 32'h5555_5555);
        access(1'b0, 32'h100, 32'd0, 4'h0, 1, 32'h1111_1112);
        lit(2, 32'd3);
        lit(1, 32'd0);
        lit(0, 32'h1111_1112);
        access(1'b0, 32'h100, 32'd0, 4'h0, 1, 32'd0);
        access(1'b1, 32'h500, 32'hFFFF_FFFF, 4'b1111, 2, 32'd0);
        access(1'b0, 32'h100, 32'd0, 4'h0, 1, 32'd0);
        lit(1, 32'd2);
        lit(0, 32'h1111_1112);

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
